// File: rtl/gzip_byte_serializer_if.sv
// Word-in / byte-out stream bundle between the output FIFO, the serializer and the sink.
// The serializer drives the master view; the environment uses the slave view.
interface gzip_byte_serializer_if #(
    parameter int unsigned BYTE_CNT_W = 32
);
    logic [34:0]           i_data;
    logic                  i_en;
    logic                  i_rdy;
    logic [7:0]            o_byte;
    logic                  o_valid;
    logic                  o_last;
    logic                  o_ready;
    logic [BYTE_CNT_W-1:0] frame_len;
    logic                  frame_done;

    modport master (
        input  i_data, i_en, o_ready,
        output i_rdy, o_byte, o_valid, o_last, frame_len, frame_done
    );

    modport slave (
        output i_data, i_en, o_ready,
        input  i_rdy, o_byte, o_valid, o_last, frame_len, frame_done
    );
endinterface

// File: rtl/gzip_byte_serializer.sv
// Serializes packed 1-4 byte words into a byte stream at one byte per cycle and
// reports the byte length of each completed gzip stream.
module gzip_byte_serializer #(
    parameter int unsigned BYTE_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    gzip_byte_serializer_if.master io
);

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [1:0]  cnt;   // valid bytes minus one
        logic [31:0] data;
    } slot_t;

    slot_t                 cur_q, cur_d;
    slot_t                 pend_q, pend_d;
    slot_t                 in_slot;
    logic [1:0]            idx_q, idx_d;
    logic                  rdy_q, rdy_d;
    logic                  ovalid_q, ovalid_d;
    logic [7:0]            obyte_q, obyte_d;
    logic                  olast_q, olast_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [BYTE_CNT_W-1:0] flen_q, flen_d;
    logic                  fdone_q, fdone_d;
    logic                  take;
    logic                  xfer;
    logic                  cur_free;
    logic                  took;

    assign in_slot = {1'b1, io.i_data};
    assign take    = io.i_en & rdy_q;
    assign xfer    = ovalid_q & io.o_ready;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_q    <= '0;
            pend_q   <= '0;
            idx_q    <= 2'd0;
            rdy_q    <= 1'b1;
            ovalid_q <= 1'b0;
            obyte_q  <= 8'd0;
            olast_q  <= 1'b0;
            cnt_q    <= '0;
            flen_q   <= '0;
            fdone_q  <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            rdy_q    <= rdy_d;
            ovalid_q <= ovalid_d;
            obyte_q  <= obyte_d;
            olast_q  <= olast_d;
            cnt_q    <= cnt_d;
            flen_q   <= flen_d;
            fdone_q  <= fdone_d;
        end
    end

    // Slot update: drain, refill CUR from PEND or input, park input in PEND
    always_comb begin
        cur_d    = cur_q;
        pend_d   = pend_q;
        idx_d    = idx_q;
        cur_free = ~cur_q.valid;
        took     = 1'b0;
        cnt_d    = cnt_q;
        flen_d   = flen_q;
        fdone_d  = 1'b0;

        if (xfer) begin
            if (idx_q < cur_q.cnt) begin
                idx_d = idx_q + 2'd1;
            end else begin
                cur_free    = 1'b1;
                cur_d.valid = 1'b0;
            end
        end

        if (cur_free) begin
            if (pend_q.valid) begin
                cur_d        = pend_q;
                pend_d.valid = 1'b0;
                idx_d        = 2'd0;
            end else if (take) begin
                cur_d = in_slot;
                idx_d = 2'd0;
                took  = 1'b1;
            end
        end

        if (take && !took) begin
            pend_d = in_slot;
        end

        // Stream length accounting; a transfer carries one byte so no same-cycle restart
        if (xfer) begin
            if (olast_q) begin
                flen_d  = cnt_q + BYTE_CNT_W'(1);
                fdone_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + BYTE_CNT_W'(1);
            end
        end

        rdy_d    = ~pend_d.valid;
        ovalid_d = cur_d.valid;
        obyte_d  = cur_d.valid ? cur_d.data[{idx_d, 3'b000} +: 8] : 8'd0;
        olast_d  = cur_d.valid & cur_d.last & (idx_d == cur_d.cnt);
    end

    assign io.i_rdy      = rdy_q;
    assign io.o_valid    = ovalid_q;
    assign io.o_byte     = obyte_q;
    assign io.o_last     = olast_q;
    assign io.frame_len  = flen_q;
    assign io.frame_done = fdone_q;

endmodule

// File: tb/tb_gzip_byte_serializer.sv
// Scoreboard bench for gzip_byte_serializer: expected bytes are queued when words are
// accepted and checked as the sink takes them; stream lengths come from a small model.
module tb_gzip_byte_serializer;

    logic clk;
    logic rstn;

    gzip_byte_serializer_if #(.BYTE_CNT_W(32)) bus ();

    gzip_byte_serializer #(.BYTE_CNT_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_acc = 0;
    int ready_mode = 0;          // 0: always ready, 1: toggle, 2: stalled
    logic [8:0] exp_q[$];        // {last, byte}
    logic [31:0] model_cnt = 0;
    logic [31:0] exp_len = 0;
    logic exp_done = 1'b0;
    logic hold_v = 1'b0;
    logic [9:0] hold_vec = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] mk_word(input bit last, input int n, input logic [31:0] d);
        return {last, 2'(n - 1), d};
    endfunction

    // Offer one word until accepted; queue its bytes at the accepting edge
    task automatic send_word(input logic [34:0] w, output int waited);
        logic [31:0] d;
        int n;
        d = w[31:0];
        n = int'(w[33:32]) + 1;
        waited = 0;
        bus.i_en = 1'b1;
        bus.i_data = w;
        forever begin
            @(negedge clk);
            if (bus.i_rdy) begin
                for (int k = 0; k < n; k++)
                    exp_q.push_back({(w[34] && k == n - 1), d[8*k +: 8]});
                n_acc++;
                @(posedge clk);
                #1;
                bus.i_en = 1'b0;
                return;
            end
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 1, 0);
                bus.i_en = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 500; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !bus.o_valid) break;
        end
        if (c == 500) check("drain_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Sink ready pattern
    initial begin
        bus.o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.o_ready = 1'b1;
                1: bus.o_ready = ~bus.o_ready;
                default: bus.o_ready = 1'b0;
            endcase
        end
    end

    // Monitor: byte scoreboard, stall stability, stream length model
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_done = 1'b0;
                hold_v = 1'b0;
            end else begin
                check("frame_done", bus.frame_done, exp_done);
                if (exp_done) check("frame_len", bus.frame_len, exp_len);
                exp_done = 1'b0;
                if (hold_v) check("stall_hold", {bus.o_valid, bus.o_last, bus.o_byte}, hold_vec);
                hold_v = bus.o_valid & ~bus.o_ready;
                hold_vec = {1'b1, bus.o_last, bus.o_byte};
                if (bus.o_valid && bus.o_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_byte", {bus.o_last, bus.o_byte}, 9'h1ff);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        check("byte", {bus.o_last, bus.o_byte}, e);
                        n_pop++;
                        if (e[8]) begin
                            exp_len = model_cnt + 32'd1;
                            model_cnt = 0;
                            exp_done = 1'b1;
                        end else begin
                            model_cnt = model_cnt + 32'd1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int maxw;
        int base;
        logic [34:0] ws[$];

        bus.i_en = 1'b0;
        bus.i_data = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_rdy", bus.i_rdy, 1);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_last", bus.o_last, 0);
        check("rst_o_byte", bus.o_byte, 0);
        check("rst_frame_len", bus.frame_len, 0);
        check("rst_frame_done", bus.frame_done, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single 4-byte last word
        send_word(mk_word(1, 4, 32'h44332211), w);
        check("first_byte_latency", {bus.o_valid, bus.o_byte}, {1'b1, 8'h11});
        wait_idle();
        check("len_4", bus.frame_len, 4);

        // Eight back-to-back 1-byte words with no bubbles
        maxw = 0;
        fork
            for (int k = 0; k < 8; k++) begin
                send_word(mk_word(k == 7, 1, 32'(k)), w);
                if (w > maxw) maxw = w;
            end
            begin
                int c;
                for (c = 0; c < 50 && !bus.o_valid; c++) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    check("no_bubble_8", bus.o_valid & bus.o_ready, 1);
                    @(negedge clk);
                end
            end
        join
        check("rdy_wait_max", maxw <= 1, 1);
        wait_idle();
        check("len_8", bus.frame_len, 8);

        // Mixed sizes with toggling ready
        ready_mode = 1;
        send_word(mk_word(0, 2, 32'h0000BBAA), w);
        send_word(mk_word(0, 1, 32'h000000CC), w);
        send_word(mk_word(0, 4, 32'h4F3E2D1C), w);
        send_word(mk_word(1, 3, 32'h00675645), w);
        wait_idle();
        ready_mode = 0;
        check("len_10", bus.frame_len, 10);

        // Long sink stall: skid fills then i_rdy drops
        base = n_acc;
        ready_mode = 2;
        fork
            begin
                send_word(mk_word(0, 4, 32'hD3C2B1A0), w);
                send_word(mk_word(0, 2, 32'h0000F5E4), w);
                send_word(mk_word(1, 3, 32'h00988776), w);
            end
            begin
                repeat (20) @(negedge clk);
                check("stall_accepted", n_acc - base, 2);
                check("stall_i_rdy", bus.i_rdy, 0);
                ready_mode = 0;
            end
        join
        wait_idle();
        check("len_9", bus.frame_len, 9);

        // Two streams back to back, lengths 5 and 3
        fork
            begin
                send_word(mk_word(0, 4, 32'h04030201), w);
                send_word(mk_word(1, 1, 32'h00000005), w);
                send_word(mk_word(1, 3, 32'h00CCBBAA), w);
            end
            begin
                int c;
                for (c = 0; c < 50 && !bus.o_valid; c++) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    check("no_bubble_2str", bus.o_valid & bus.o_ready, 1);
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        check("len_3", bus.frame_len, 3);

        // Reset in the middle of a 4-byte word
        base = n_pop;
        send_word(mk_word(1, 4, 32'h87654321), w);
        for (int c = 0; c < 50 && n_pop < base + 2; c++) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_o_valid", bus.o_valid, 0);
        check("midrst_i_rdy", bus.i_rdy, 1);
        check("midrst_frame_len", bus.frame_len, 0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", bus.o_valid, 0);
        send_word(mk_word(1, 1, 32'h000000A5), w);
        check("post_rst_byte", {bus.o_valid, bus.o_last, bus.o_byte}, {1'b1, 1'b1, 8'hA5});
        wait_idle();
        check("len_1", bus.frame_len, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
